// File: rtl/spi_bus_arbiter_pkg.sv
// Shared definitions for the SPI bus arbiter and its shift engine.
// Requester indices, FSM encoding and frame-length width.
package spi_bus_arbiter_pkg;

    localparam logic REQ_DAC = 1'b0;
    localparam logic REQ_ROM = 1'b1;
    localparam int   N_REQ   = 2;
    localparam int   LEN_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } state_e;

    function automatic logic [LEN_W-1:0] clamp_len(
        input logic [LEN_W-1:0] len,
        input logic [LEN_W-1:0] max_len
    );
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 MSB-first SPI frame engine: SCK divider, shift registers
// and IDLE/SETUP/SHIFT/HOLD frame timing.
module spi_shift_engine
    import spi_bus_arbiter_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] start_data,
    input  logic [LEN_W-1:0]  start_len,
    input  logic              miso,
    output logic              idle,
    output logic              active,
    output logic              sck,
    output logic              mosi,
    output logic              fin,
    output logic [DATA_W-1:0] fin_data
);

    localparam int CW = $clog2(2 * CLK_DIV + 1);
    localparam logic [CW-1:0]  HALF = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  GAP  = CW'(2 * CLK_DIV - 1);
    localparam logic [LEN_W:0] DW   = (LEN_W + 1)'(DATA_W);

    state_e            state_q;
    state_e            state_d;
    logic [CW-1:0]     cnt_q;
    logic [LEN_W-1:0]  bits_q;
    logic              sck_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic              cnt_zero;
    logic              zero_len;
    logic              last_bit;
    logic              sample;
    logic [LEN_W:0]    shamt;

    assign cnt_zero = (cnt_q == '0);
    assign zero_len = (start_len == '0);
    assign last_bit = (bits_q == '0);
    assign sample   = (state_q == ST_SHIFT) && sck_q && (cnt_q == HALF);
    assign shamt    = DW - {1'b0, start_len};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = zero_len ? ST_HOLD : ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_zero && !sck_q && last_bit) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idle   = 1'b0;
        active = 1'b0;
        fin    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                idle = 1'b1;
                fin  = start && zero_len;
            end
            ST_SETUP: begin
                active = 1'b1;
            end
            ST_SHIFT: begin
                active = 1'b1;
                fin    = cnt_zero && !sck_q && last_bit;
            end
            default: begin
            end
        endcase
    end

    assign sck      = sck_q;
    assign mosi     = active & tx_q[DATA_W-1];
    assign fin_data = idle ? '0 : rx_q;

    // Data is left-justified at load so the MSB is always the bit on the wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            bits_q <= '0;
            sck_q  <= 1'b0;
            tx_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q  <= zero_len ? GAP : HALF;
                        bits_q <= start_len;
                        tx_q   <= start_data << shamt;
                    end
                end
                ST_SETUP: begin
                    if (cnt_zero) begin
                        sck_q <= 1'b1;
                        cnt_q <= HALF;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (sck_q) begin
                        sck_q  <= 1'b0;
                        cnt_q  <= HALF;
                        tx_q   <= tx_q << 1;
                        bits_q <= bits_q - LEN_W'(1);
                    end else if (last_bit) begin
                        cnt_q <= GAP;
                    end else begin
                        sck_q <= 1'b1;
                        cnt_q <= HALF;
                    end
                end
                ST_HOLD: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q <= '0;
        end else if (idle && start) begin
            rx_q <= '0;
        end else if (sample) begin
            rx_q <= {rx_q[DATA_W-2:0], miso};
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared board SPI bus (DAC and serial ROM).
// Grants one requester per frame and decodes its chip select.
module spi_bus_arbiter
    import spi_bus_arbiter_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ*LEN_W-1:0]    req_len,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_done,
    output logic [N_REQ*DATA_W-1:0]   rsp_data,
    output logic                      busy,
    output logic                      spi_sck,
    output logic                      spi_mosi,
    input  logic                      spi_miso,
    output logic                      dac_cs_n,
    output logic                      rom_cs_n,
    output logic                      amp_cs_n,
    output logic                      adc_conv,
    output logic                      dac_clr_n
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

    logic              clr_q;
    logic              last_q;
    logic              owner_q;
    logic              gnt_idx;
    logic              accept;
    logic              fin_owner;
    logic              eng_idle;
    logic              eng_active;
    logic              eng_sck;
    logic              eng_mosi;
    logic              fin;
    logic [DATA_W-1:0] fin_data;
    logic [DATA_W-1:0] sel_data;
    logic [LEN_W-1:0]  sel_len;

    always_comb begin
        gnt_idx = REQ_DAC;
        unique case (1'b1)
            (req_valid == 2'b11): gnt_idx = ~last_q;
            (req_valid == 2'b10): gnt_idx = REQ_ROM;
            default:              gnt_idx = REQ_DAC;
        endcase
    end

    // clr_q doubles as a "reset released" flag so nothing is accepted during reset.
    assign accept    = eng_idle && clr_q && (req_valid != '0);
    assign req_ready = !accept ? 2'b00 : (gnt_idx ? 2'b10 : 2'b01);
    assign fin_owner = eng_idle ? gnt_idx : owner_q;

    assign sel_data = gnt_idx ? req_data[2*DATA_W-1:DATA_W]
                              : req_data[DATA_W-1:0];
    assign sel_len  = clamp_len(gnt_idx ? req_len[2*LEN_W-1:LEN_W]
                                        : req_len[LEN_W-1:0], MAX_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_q   <= 1'b0;
            last_q  <= REQ_ROM;
            owner_q <= REQ_DAC;
        end else begin
            clr_q <= 1'b1;
            if (accept) begin
                last_q  <= gnt_idx;
                owner_q <= gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_done <= '0;
            rsp_data <= '0;
        end else begin
            rsp_done <= '0;
            if (fin) begin
                if (fin_owner) begin
                    rsp_done <= 2'b10;
                    rsp_data[2*DATA_W-1:DATA_W] <= fin_data;
                end else begin
                    rsp_done <= 2'b01;
                    rsp_data[DATA_W-1:0] <= fin_data;
                end
            end
        end
    end

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) u_engine (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (accept),
        .start_data (sel_data),
        .start_len  (sel_len),
        .miso       (spi_miso),
        .idle       (eng_idle),
        .active     (eng_active),
        .sck        (eng_sck),
        .mosi       (eng_mosi),
        .fin        (fin),
        .fin_data   (fin_data)
    );

    assign busy      = ~eng_idle;
    assign spi_sck   = eng_sck;
    assign spi_mosi  = eng_mosi;
    assign dac_cs_n  = ~(eng_active && (owner_q == REQ_DAC));
    assign rom_cs_n  = ~(eng_active && (owner_q == REQ_ROM));
    assign amp_cs_n  = 1'b1;
    assign adc_conv  = 1'b0;
    assign dac_clr_n = clr_q;

endmodule
